// File: rtl/line_break_sequencer.sv
// -----------------------------------------------------------------------------
// line_break_sequencer
//
// Frame-level controller that sits behind the per-frame half-break detector.
// One verdict arrives per frame (det_valid strobe, det_break level). After
// enable, a number of warm-up verdicts are discarded. A break is then confirmed
// over CONFIRM_FRAMES consecutive break verdicts. The confirmed break is held
// as a request to the motion controller until it is acknowledged. A cooldown
// window follows the acknowledge. A cycle watchdog flags a stalled camera.
//
// Ports
//   pclk       in   pixel clock, sole clock
//   reset_n    in   asynchronous active-low reset
//   enable     in   run control, low forces IDLE
//   det_valid  in   one-cycle frame-end strobe from the detector
//   det_break  in   detector verdict, qualified by det_valid
//   break_ack  in   acknowledge of break_req, only honoured in REQ
//   fault_clr  in   one-cycle pulse that leaves FAULT
//   break_req  out  high while in REQ
//   fault      out  high while in FAULT
//   state      out  current state code (IDLE=0 .. FAULT=6)
//   frame_cnt  out  verdicts seen while enabled, wraps
//   break_cnt  out  acknowledged breaks, saturates at 255
// -----------------------------------------------------------------------------
module line_break_sequencer #(
    parameter int unsigned WARMUP_FRAMES   = 4,
    parameter int unsigned CONFIRM_FRAMES  = 3,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned TIMEOUT_CYC     = 2000000
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        det_valid,
    input  logic        det_break,
    input  logic        break_ack,
    input  logic        fault_clr,
    output logic        break_req,
    output logic        fault,
    output logic [2:0]  state,
    output logic [15:0] frame_cnt,
    output logic [7:0]  break_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WARMUP   = 3'd1,
        S_TRACK    = 3'd2,
        S_CONFIRM  = 3'd3,
        S_REQ      = 3'd4,
        S_COOLDOWN = 3'd5,
        S_FAULT    = 3'd6
    } state_e;

    localparam logic [15:0] WARM_LIM  = 16'(WARMUP_FRAMES);
    localparam logic [15:0] CONF_LIM  = 16'(CONFIRM_FRAMES);
    localparam logic [15:0] COOL_LIM  = 16'(COOLDOWN_FRAMES);
    localparam logic [23:0] WDOG_LAST = 24'(TIMEOUT_CYC - 1);

    // Skipping WARMUP/COOLDOWN entirely when their frame count is zero.
    localparam state_e START_ST = (WARMUP_FRAMES == 0)   ? S_TRACK : S_WARMUP;
    localparam state_e ACK_ST   = (COOLDOWN_FRAMES == 0) ? S_TRACK : S_COOLDOWN;
    localparam state_e HIT_ST   = (CONFIRM_FRAMES == 1)  ? S_REQ   : S_CONFIRM;

    state_e      state_q, state_d;
    logic [15:0] wcnt_q, wcnt_d;       // shared by WARMUP and COOLDOWN
    logic [15:0] streak_q, streak_d;
    logic [23:0] wdog_q, wdog_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  break_cnt_q, break_cnt_d;
    logic        brk_inc;
    logic        wdog_active;
    logic        wdog_timeout;
    logic        verdict;
    logic        brk_verdict;

    assign verdict     = det_valid;
    assign brk_verdict = det_valid & det_break;

    assign wdog_active = (state_q == S_WARMUP) || (state_q == S_TRACK) ||
                         (state_q == S_CONFIRM) || (state_q == S_COOLDOWN);
    // A verdict arriving in the timeout cycle rescues the camera.
    assign wdog_timeout = wdog_active && !det_valid && (wdog_q == WDOG_LAST);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            streak_q    <= '0;
            wdog_q      <= '0;
            frame_cnt_q <= '0;
            break_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            streak_q    <= streak_d;
            wdog_q      <= wdog_d;
            frame_cnt_q <= frame_cnt_d;
            break_cnt_q <= break_cnt_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        streak_d = streak_q;
        brk_inc  = 1'b0;

        if (!enable) begin
            state_d  = S_IDLE;
            wcnt_d   = '0;
            streak_d = '0;
        end else if (wdog_timeout) begin
            state_d  = S_FAULT;
            wcnt_d   = '0;
            streak_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d  = START_ST;
                    wcnt_d   = '0;
                    streak_d = '0;
                end
                S_WARMUP: begin
                    if (verdict) begin
                        if (wcnt_q + 16'd1 >= WARM_LIM) begin
                            state_d = S_TRACK;
                            wcnt_d  = '0;
                        end else begin
                            wcnt_d = wcnt_q + 16'd1;
                        end
                    end
                end
                S_TRACK: begin
                    if (brk_verdict) begin
                        state_d  = HIT_ST;
                        streak_d = (CONFIRM_FRAMES == 1) ? 16'd0 : 16'd1;
                    end
                end
                S_CONFIRM: begin
                    if (brk_verdict) begin
                        if (streak_q + 16'd1 >= CONF_LIM) begin
                            state_d  = S_REQ;
                            streak_d = '0;
                        end else begin
                            streak_d = streak_q + 16'd1;
                        end
                    end else if (verdict) begin
                        state_d  = S_TRACK;
                        streak_d = '0;
                    end
                end
                S_REQ: begin
                    // Verdicts are ignored; only the acknowledge moves on.
                    if (break_ack) begin
                        state_d  = ACK_ST;
                        wcnt_d   = '0;
                        streak_d = '0;
                        brk_inc  = 1'b1;
                    end
                end
                S_COOLDOWN: begin
                    if (verdict) begin
                        if (wcnt_q + 16'd1 >= COOL_LIM) begin
                            state_d  = S_TRACK;
                            wcnt_d   = '0;
                            streak_d = '0;
                        end else begin
                            wcnt_d = wcnt_q + 16'd1;
                        end
                    end
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        state_d  = START_ST;
                        wcnt_d   = '0;
                        streak_d = '0;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    wcnt_d   = '0;
                    streak_d = '0;
                end
            endcase
        end
    end

    // Watchdog restarts on any verdict and on every state change, and idles
    // at zero outside the frame-consuming states.
    always_comb begin
        if (!wdog_active || det_valid || (state_d != state_q)) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + 24'd1;
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (enable && det_valid) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        break_cnt_d = break_cnt_q;
        if (brk_inc && (break_cnt_q != 8'hFF)) begin
            break_cnt_d = break_cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        break_req = (state_q == S_REQ);
        fault     = (state_q == S_FAULT);
        state     = state_q;
        frame_cnt = frame_cnt_q;
        break_cnt = break_cnt_q;
    end

endmodule

// File: tb/tb_line_break_sequencer.sv
module tb_line_break_sequencer;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        en, dv, db, ack, clr;
    logic        req, flt;
    logic [2:0]  st;
    logic [15:0] fc;
    logic [7:0]  bc;

    logic        s_en, s_dv, s_db, s_ack;
    logic        s_req, s_flt;
    logic [2:0]  s_st;
    logic [15:0] s_fc;
    logic [7:0]  s_bc;

    int n_chk = 0;
    int n_fail = 0;

    always #5 pclk = ~pclk;

    line_break_sequencer #(
        .WARMUP_FRAMES(2), .CONFIRM_FRAMES(3), .COOLDOWN_FRAMES(2), .TIMEOUT_CYC(100)
    ) u_dut (
        .pclk(pclk), .reset_n(rst_n), .enable(en), .det_valid(dv), .det_break(db),
        .break_ack(ack), .fault_clr(clr), .break_req(req), .fault(flt),
        .state(st), .frame_cnt(fc), .break_cnt(bc)
    );

    // Fast-cycling instance for the break counter saturation check.
    line_break_sequencer #(
        .WARMUP_FRAMES(0), .CONFIRM_FRAMES(1), .COOLDOWN_FRAMES(0), .TIMEOUT_CYC(100)
    ) u_sat (
        .pclk(pclk), .reset_n(rst_n), .enable(s_en), .det_valid(s_dv), .det_break(s_db),
        .break_ack(s_ack), .fault_clr(1'b0), .break_req(s_req), .fault(s_flt),
        .state(s_st), .frame_cnt(s_fc), .break_cnt(s_bc)
    );

    typedef struct {
        logic        en, dv, db, ack, clr;
        logic [2:0]  st;
        logic        req, flt;
        logic [15:0] fc;
        logic [7:0]  bc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic e, input logic v, input logic b, input logic a,
                                input logic c, input int s, input logic r, input logic f,
                                input int fcnt, input int bcnt);
        vec_t t;
        t.en = e; t.dv = v; t.db = b; t.ack = a; t.clr = c;
        t.st = 3'(s); t.req = r; t.flt = f; t.fc = 16'(fcnt); t.bc = 8'(bcnt);
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive(input logic e, input logic v, input logic b, input logic a, input logic c);
        en = e; dv = v; db = b; ack = a; clr = c;
    endtask

    task automatic chk_main(input string tag, input int s, input int r, input int f, input int fcnt, input int bcnt);
        chk({tag, " state"}, int'(st), s);
        chk({tag, " break_req"}, int'(req), r);
        chk({tag, " fault"}, int'(flt), f);
        chk({tag, " frame_cnt"}, int'(fc), fcnt);
        chk({tag, " break_cnt"}, int'(bc), bcnt);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        s_en = 0; s_dv = 0; s_db = 0; s_ack = 0;
        tick(); tick();
        chk_main("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_main("idle", 0, 0, 0, 0, 0);

        //            en dv db ak cl  st rq ft fc bc
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 2, 0, 0, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2, 0, 0, 2, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 3, 0, 0, 3, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 0, 0, 3, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 3, 0, 0, 4, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 4, 1, 0, 5, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 4, 1, 0, 6, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 6, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 5, 0, 0, 6, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 5, 0, 0, 6, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 5, 0, 0, 7, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 2, 0, 0, 8, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 3, 0, 0, 9, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 3, 0, 0, 10, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0, 11, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 3, 0, 0, 12, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 3, 0, 0, 13, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 4, 1, 0, 14, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 14, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 14, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 14, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 15, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2, 0, 0, 16, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 2, 0, 0, 16, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].dv, tbl[i].db, tbl[i].ack, tbl[i].clr);
            tick();
            chk_main($sformatf("row%0d", i), int'(tbl[i].st), int'(tbl[i].req),
                     int'(tbl[i].flt), int'(tbl[i].fc), int'(tbl[i].bc));
        end

        // Watchdog: verdict in the would-be timeout cycle rescues, then a real stall.
        drive(1, 1, 0, 0, 0); tick();               // frame 17, watchdog restart
        drive(1, 0, 0, 0, 0);
        repeat (99) tick();
        chk("wdog pre-rescue state", int'(st), 2);
        drive(1, 1, 0, 0, 0); tick();               // 100th cycle carries a verdict
        chk("wdog rescue state", int'(st), 2);
        chk("wdog rescue fault", int'(flt), 0);
        drive(1, 0, 0, 0, 0);
        repeat (99) tick();
        chk("wdog 99 idle state", int'(st), 2);
        tick();
        chk_main("wdog timeout", 6, 0, 1, 18, 1);
        drive(1, 1, 1, 0, 0); tick();
        chk_main("fault sticky", 6, 0, 1, 19, 1);
        drive(1, 0, 0, 0, 1); tick();
        chk_main("fault clear", 1, 0, 0, 19, 1);

        // Back to REQ, then assert reset between clock edges.
        drive(1, 1, 0, 0, 0); tick(); tick();
        chk("rearm track", int'(st), 2);
        drive(1, 1, 1, 0, 0); tick(); tick(); tick();
        drive(1, 0, 0, 0, 0);
        chk("rearm req", int'(req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_main("async reset", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;

        // Frame counter wrap: 65537 verdicts from zero.
        drive(1, 1, 0, 0, 0);
        repeat (65537) tick();
        chk("frame wrap cnt", int'(fc), 1);
        chk("frame wrap state", int'(st), 2);
        drive(0, 0, 0, 0, 0);
        tick();

        // Break counter saturation on the fast instance: one ack every two cycles.
        s_en = 1; s_dv = 1; s_db = 1; s_ack = 1;
        repeat (3) tick();
        chk("sat first ack", int'(s_bc), 1);
        repeat (507) tick();
        chk("sat 254", int'(s_bc), 254);
        chk("sat req state", int'(s_st), 4);
        tick();
        chk("sat 255", int'(s_bc), 255);
        repeat (4) tick();
        chk("sat hold", int'(s_bc), 255);
        s_en = 0; s_dv = 0; s_db = 0; s_ack = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
